vote_window_sequencer: RTL

- Serial front-end and controller for the 4-input "two-or-three-of-four" vote check.
- Accepts a bit stream over a valid/ready handshake and packs consecutive bits into 4-bit windows.
- Evaluates each window against the vote rule and presents a registered verdict over a second valid/ready handshake.
- Keeps a saturating count of windows that passed. Sits between a serial bit source and any consumer of per-window verdicts.

---
 rtl/vote_window_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vote_window_sequencer.sv
`default_nettype none
// ============================================================================
// vote_window_sequencer: packs a serial bit stream into 4-bit windows and
// issues a registered 2-or-3-of-4 verdict per window (option: VOTE_POPCNT_EN).
// Revision: 1.0
// ============================================================================
module vote_window_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  input  logic             clear,
  output logic [CNT_W-1:0] hit_count
`ifdef VOTE_POPCNT_EN
  ,
  output logic [2:0]       out_popcnt
`endif
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EVAL    = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_bit_idx;
  logic [3:0]         r_window;
  logic               r_hit;
  logic [CNT_W-1:0]   r_count;
  logic               w_accept;
  logic               w_out_fire;
  logic               w_vote;

  assign in_ready   = (r_state == S_COLLECT);
  assign out_valid  = (r_state == S_HOLD);
  assign out_hit    = r_hit;
  assign hit_count  = r_count;
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Pair-carry catches both ones in one pair; cross-pair-any catches one in
  // each pair. Four ones satisfies both, so it is masked explicitly.
  assign w_vote = ((r_window[0] & r_window[1]) | (r_window[2] & r_window[3]) |
                   ((r_window[0] | r_window[1]) & (r_window[2] | r_window[3])))
                  & ~(&r_window);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_COLLECT: if (w_accept && (r_bit_idx == 2'd3)) w_next_state = S_EVAL;
      S_EVAL:    w_next_state = S_HOLD;
      S_HOLD:    if (w_out_fire) w_next_state = S_COLLECT;
      default:   w_next_state = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_idx <= 2'd0;
      r_window  <= 4'b0000;
      r_hit     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_window[r_bit_idx] <= in_bit;
        r_bit_idx           <= r_bit_idx + 2'd1;
      end
      if (r_state == S_EVAL) begin
        r_hit <= w_vote;
      end
      if (w_out_fire) begin
        r_window <= 4'b0000;
      end
    end
  end

`ifdef VOTE_POPCNT_EN
  logic [2:0] r_popcnt;
  logic [2:0] w_popcnt;

  assign w_popcnt   = 3'(r_window[0]) + 3'(r_window[1]) +
                      3'(r_window[2]) + 3'(r_window[3]);
  assign out_popcnt = r_popcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_popcnt <= 3'd0;
    end else if (r_state == S_EVAL) begin
      r_popcnt <= w_popcnt;
    end
  end
`endif

  // Clear wins over a same-edge increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (w_out_fire && r_hit && (r_count != C_CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire
